univ_shift_reg: RTL and testbench

//  Parametrised universal register: parallel load, hold, clear, shift, rotate, arithmetic shift.

---
 rtl/univ_shift_reg.sv | 135 +++++++++++++
 tb/tb_univ_shift_reg.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: load/hold/clear/shift/rotate/ASR, single-step under en or N-step bursts via start.
// Optional even-parity output q_par is enabled by defining UREG_PARITY_EN.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
`ifdef UREG_PARITY_EN
  output logic             q_par,
`endif
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_LOAD = 3'd1;
  localparam logic [2:0] M_SHL  = 3'd2;
  localparam logic [2:0] M_SHR  = 3'd3;
  localparam logic [2:0] M_ROL  = 3'd4;
  localparam logic [2:0] M_ROR  = 3'd5;
  localparam logic [2:0] M_ASR  = 3'd6;
  localparam logic [2:0] M_CLR  = 3'd7;

  localparam logic [CNT_W-1:0] W_CNT   = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q_n;
  logic [CNT_W-1:0] cnt, cnt_n, amt_sat;
  logic [2:0]       mode_lat, mode_lat_n;
  logic             done_n;
  logic             is_shift;

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] m, input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] ld, input logic sl,
                                                input logic sr);
    logic [WIDTH-1:0] r;
    r = cur;
    case (m)
      M_LOAD: r = ld;
      M_SHL:  r = {cur[WIDTH-2:0], sr};
      M_SHR:  r = {sl, cur[WIDTH-1:1]};
      M_ROL:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROR:  r = {cur[0], cur[WIDTH-1:1]};
      M_ASR:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
      M_CLR:  r = '0;
      default: r = cur;
    endcase
    return r;
  endfunction

  assign amt_sat  = (amount > W_CNT) ? W_CNT : amount;
  assign is_shift = (mode >= M_SHL) && (mode <= M_ASR);
  assign busy     = (state == SHIFT);
  assign sout_l   = q[WIDTH-1];
  assign sout_r   = q[0];

  always_comb begin
    state_n    = state;
    q_n        = q;
    cnt_n      = cnt;
    mode_lat_n = mode_lat;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          done_n = 1'b1;
          if (is_shift && (amount != '0)) begin
            // First step of the burst lands on the start edge itself.
            q_n        = apply_op(mode, q, d, sin_l, sin_r);
            mode_lat_n = mode;
            cnt_n      = amt_sat - ONE_CNT;
            if (amt_sat != ONE_CNT) begin
              state_n = SHIFT;
              done_n  = 1'b0;
            end
          end else if (!is_shift) begin
            q_n = apply_op(mode, q, d, sin_l, sin_r);
          end
        end else if (en) begin
          q_n = apply_op(mode, q, d, sin_l, sin_r);
        end
      end
      SHIFT: begin
        q_n = apply_op(mode_lat, q, d, sin_l, sin_r);
        if (cnt == ONE_CNT) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt - ONE_CNT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      q        <= '0;
      cnt      <= '0;
      mode_lat <= M_HOLD;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      q        <= q_n;
      cnt      <= cnt_n;
      mode_lat <= mode_lat_n;
      done     <= done_n;
    end
  end

`ifdef UREG_PARITY_EN
  // Registered alongside q so it always equals ^q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_par <= 1'b0;
    else        q_par <= ^q_n;
  end
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8); checks sampled 1 time unit after each rising edge.
module tb_univ_shift_reg;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_r, sin_l, start;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] q;
  logic             sout_l, sout_r, busy, done;
`ifdef UREG_PARITY_EN
  logic             q_par;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .sin_r(sin_r), .sin_l(sin_l),
    .start(start), .amount(amount), .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy),
`ifdef UREG_PARITY_EN
    .q_par(q_par),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
`ifdef UREG_PARITY_EN
    chk("q_par", {31'b0, q_par}, {31'b0, ^q});
`endif
  endtask

  task automatic chk_st(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    chk({tag, "_q"}, {24'b0, q}, {24'b0, eq});
    chk({tag, "_busy"}, {31'b0, busy}, {31'b0, eb});
    chk({tag, "_done"}, {31'b0, done}, {31'b0, ed});
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 3'd0; d = '0; sin_r = 1'b0; sin_l = 1'b0;
    start = 1'b0; amount = '0;
    #3;
    chk_st("reset", 8'h00, 1'b0, 1'b0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk_st("idle_after_reset", 8'h00, 1'b0, 1'b0);

    // Single-step LOAD then two ASR
    en = 1'b1; mode = 3'd1; d = 8'hA5;
    step(); chk_st("load_a5", 8'hA5, 1'b0, 1'b0);
    mode = 3'd6;
    step(); chk_st("asr1", 8'hD2, 1'b0, 1'b0);
    step(); chk_st("asr2", 8'hE9, 1'b0, 1'b0);
    chk("sout_l", {31'b0, sout_l}, 32'd1);
    chk("sout_r", {31'b0, sout_r}, 32'd1);

    // Burst ROL by 3 from 81, with an ignored LOAD attempt while busy
    mode = 3'd1; d = 8'h81;
    step(); chk_st("load_81", 8'h81, 1'b0, 1'b0);
    en = 1'b0; start = 1'b1; mode = 3'd4; amount = 4'd3;
    step(); chk_st("rol_e1", 8'h03, 1'b1, 1'b0);
    start = 1'b0; en = 1'b1; mode = 3'd1; d = 8'h00;
    step(); chk_st("rol_e2", 8'h06, 1'b1, 1'b0);
    step(); chk_st("rol_e3", 8'h0C, 1'b0, 1'b1);
    en = 1'b0; mode = 3'd0;
    step(); chk_st("rol_after", 8'h0C, 1'b0, 1'b0);

    // Burst SHR by 15 (saturates to 8) with sin_l=1 from F0
    en = 1'b1; mode = 3'd1; d = 8'hF0;
    step(); en = 1'b0;
    chk("load_f0", {24'b0, q}, 32'hF0);
    start = 1'b1; mode = 3'd3; amount = 4'd15; sin_l = 1'b1;
    step(); chk_st("shr_e1", 8'hF8, 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      step();
      chk("shr_busy", {31'b0, busy}, {31'b0, (i < 8)});
      chk("shr_done", {31'b0, done}, {31'b0, (i == 8)});
    end
    chk("shr_final", {24'b0, q}, 32'hFF);

    // Back-to-back start in the done cycle: SHL by 1 completes without busy
    start = 1'b1; mode = 3'd2; amount = 4'd1; sin_r = 1'b0;
    step(); chk_st("shl1", 8'hFE, 1'b0, 1'b1);

    // amount=0 with a shift mode leaves q alone but still pulses done
    amount = 4'd0;
    step(); chk_st("amt0", 8'hFE, 1'b0, 1'b1);
    start = 1'b0;
    step(); chk_st("amt0_after", 8'hFE, 1'b0, 1'b0);

    // Burst CLR
    start = 1'b1; mode = 3'd7; amount = 4'd5;
    step(); chk_st("clr", 8'h00, 1'b0, 1'b1);
    start = 1'b0;
    step(); chk_st("clr_after", 8'h00, 1'b0, 1'b0);

    // Rotate by WIDTH restores the original value
    en = 1'b1; mode = 3'd1; d = 8'h5A;
    step(); en = 1'b0;
    start = 1'b1; mode = 3'd5; amount = 4'd8;
    step(); chk_st("ror_e1", 8'h2D, 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 2; i <= 8; i++) step();
    chk_st("ror8", 8'h5A, 1'b0, 1'b1);

    // Parity check value
    en = 1'b1; mode = 3'd1; d = 8'h07;
    step(); en = 1'b0;
    chk("load_07", {24'b0, q}, 32'h07);
`ifdef UREG_PARITY_EN
    chk("q_par_07", {31'b0, q_par}, 32'd1);
`endif

    // Reset mid-burst aborts with no done
    en = 1'b1; mode = 3'd1; d = 8'h3C;
    step(); en = 1'b0;
    start = 1'b1; mode = 3'd4; amount = 4'd5;
    step(); chk_st("rst_rol_e1", 8'h78, 1'b1, 1'b0);
    start = 1'b0;
    step(); chk_st("rst_rol_e2", 8'hF0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_st("rst_mid", 8'h00, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_st("post_rst", 8'h00, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
